// File: rtl/match_controller.sv
// Pong match sequencer: serve selection, rally, scoring, inter-point pause and match-over.
// Optional auto-serve timeout is enabled by defining MATCH_CTRL_AUTO_SERVE_EN.
module match_controller #(
    parameter int unsigned SCORE_WIDTH      = 4,
    parameter int unsigned WIN_SCORE        = 11,
    parameter int unsigned PAUSE_TICKS      = 60,
    parameter int unsigned FIRST_SERVER     = 0,
    parameter int unsigned AUTO_SERVE_TICKS = 180
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_tick,
    input  logic                   i_left_click,
    input  logic                   i_right_click,
    input  logic                   i_left_miss,
    input  logic                   i_right_miss,
    output logic                   o_left_will_start,
    output logic                   o_right_will_start,
    output logic                   o_ball_in_game,
    output logic                   o_game_over,
    output logic                   o_left_winner,
    output logic                   o_point,
    output logic [SCORE_WIDTH-1:0] o_left_score,
    output logic [SCORE_WIDTH-1:0] o_right_score,
    output logic [2:0]             o_state
);

    localparam int unsigned PAUSE_W = (PAUSE_TICKS > 0) ? $clog2(PAUSE_TICKS + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'b000,
        ST_LEFT_SERVE  = 3'b001,
        ST_RIGHT_SERVE = 3'b010,
        ST_IN_PLAY     = 3'b011,
        ST_POINT_PAUSE = 3'b100,
        ST_GAME_OVER   = 3'b101
    } state_e;

    // Elaboration-time parameter sanity checks
    if (WIN_SCORE < 1 || WIN_SCORE > (2 ** SCORE_WIDTH) - 1) begin : g_bad_win
        $error("WIN_SCORE out of range");
    end
    if (AUTO_SERVE_TICKS < 1) begin : g_bad_auto
        $error("AUTO_SERVE_TICKS must be at least 1");
    end

    state_e                 state_q, state_d;
    logic [SCORE_WIDTH-1:0] left_score_q, left_score_d;
    logic [SCORE_WIDTH-1:0] right_score_q, right_score_d;
    logic [PAUSE_W-1:0]     pause_cnt_q, pause_cnt_d;
    logic                   pend_right_q, pend_right_d;
    logic                   point_q, point_d;
    logic                   auto_fire;
    logic                   win_reached;

`ifdef MATCH_CTRL_AUTO_SERVE_EN
    localparam int unsigned SERVE_W = $clog2(AUTO_SERVE_TICKS + 1);

    logic [SERVE_W-1:0] serve_cnt_q, serve_cnt_d;
    logic               in_serve;

    assign in_serve  = (state_q == ST_LEFT_SERVE) || (state_q == ST_RIGHT_SERVE);
    // Fires on the tick that brings the count to AUTO_SERVE_TICKS
    assign auto_fire = in_serve && i_tick && (serve_cnt_q == SERVE_W'(AUTO_SERVE_TICKS - 1));

    always_comb begin
        serve_cnt_d = '0;
        if (in_serve) begin
            serve_cnt_d = i_tick ? serve_cnt_q + SERVE_W'(1) : serve_cnt_q;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            serve_cnt_q <= '0;
        end else begin
            serve_cnt_q <= serve_cnt_d;
        end
    end
`else
    assign auto_fire = 1'b0;
`endif

    assign win_reached = (left_score_q == SCORE_WIDTH'(WIN_SCORE)) ||
                         (right_score_q == SCORE_WIDTH'(WIN_SCORE));

    // Next-state, score and pause-counter logic
    always_comb begin
        state_d       = state_q;
        left_score_d  = left_score_q;
        right_score_d = right_score_q;
        pause_cnt_d   = pause_cnt_q;
        pend_right_d  = pend_right_q;
        point_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                left_score_d  = '0;
                right_score_d = '0;
                pend_right_d  = (FIRST_SERVER != 0);
                state_d       = (FIRST_SERVER != 0) ? ST_RIGHT_SERVE : ST_LEFT_SERVE;
            end
            ST_LEFT_SERVE: begin
                if (i_left_click || auto_fire) begin
                    state_d = ST_IN_PLAY;
                end
            end
            ST_RIGHT_SERVE: begin
                if (i_right_click || auto_fire) begin
                    state_d = ST_IN_PLAY;
                end
            end
            ST_IN_PLAY: begin
                // Left miss has priority when both sides miss together
                if (i_left_miss) begin
                    right_score_d = right_score_q + SCORE_WIDTH'(1);
                    pend_right_d  = 1'b1;
                    pause_cnt_d   = '0;
                    point_d       = 1'b1;
                    state_d       = ST_POINT_PAUSE;
                end else if (i_right_miss) begin
                    left_score_d = left_score_q + SCORE_WIDTH'(1);
                    pend_right_d = 1'b0;
                    pause_cnt_d  = '0;
                    point_d      = 1'b1;
                    state_d      = ST_POINT_PAUSE;
                end
            end
            ST_POINT_PAUSE: begin
                if (pause_cnt_q == PAUSE_W'(PAUSE_TICKS)) begin
                    if (win_reached) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d = pend_right_q ? ST_RIGHT_SERVE : ST_LEFT_SERVE;
                    end
                end else if (i_tick) begin
                    pause_cnt_d = pause_cnt_q + PAUSE_W'(1);
                end
            end
            ST_GAME_OVER: begin
                if (i_left_click || i_right_click) begin
                    left_score_d  = '0;
                    right_score_d = '0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                left_score_d  = '0;
                right_score_d = '0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= ST_IDLE;
            left_score_q  <= '0;
            right_score_q <= '0;
            pause_cnt_q   <= '0;
            pend_right_q  <= (FIRST_SERVER != 0);
            point_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            left_score_q  <= left_score_d;
            right_score_q <= right_score_d;
            pause_cnt_q   <= pause_cnt_d;
            pend_right_q  <= pend_right_d;
            point_q       <= point_d;
        end
    end

    assign o_state            = state_q;
    assign o_left_will_start  = (state_q == ST_LEFT_SERVE);
    assign o_right_will_start = (state_q == ST_RIGHT_SERVE);
    assign o_ball_in_game     = (state_q == ST_IN_PLAY);
    assign o_game_over        = (state_q == ST_GAME_OVER);
    assign o_left_winner      = (state_q == ST_GAME_OVER) &&
                                (left_score_q == SCORE_WIDTH'(WIN_SCORE));
    assign o_point            = point_q;
    assign o_left_score       = left_score_q;
    assign o_right_score      = right_score_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with WIN_SCORE=2, PAUSE_TICKS=3, AUTO_SERVE_TICKS=4.
module tb_match_controller;

    localparam int unsigned SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic          lclick = 1'b0;
    logic          rclick = 1'b0;
    logic          lmiss = 1'b0;
    logic          rmiss = 1'b0;
    logic          lws, rws, big, go, lwin, point;
    logic [SW-1:0] lscore, rscore;
    logic [2:0]    state;

    int n_cmp = 0;
    int n_err = 0;

    match_controller #(
        .SCORE_WIDTH     (SW),
        .WIN_SCORE       (2),
        .PAUSE_TICKS     (3),
        .FIRST_SERVER    (0),
        .AUTO_SERVE_TICKS(4)
    ) dut (
        .i_clock           (clk),
        .i_reset_n         (rst_n),
        .i_tick            (tick),
        .i_left_click      (lclick),
        .i_right_click     (rclick),
        .i_left_miss       (lmiss),
        .i_right_miss      (rmiss),
        .o_left_will_start (lws),
        .o_right_will_start(rws),
        .o_ball_in_game    (big),
        .o_game_over       (go),
        .o_left_winner     (lwin),
        .o_point           (point),
        .o_left_score      (lscore),
        .o_right_score     (rscore),
        .o_state           (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic pause_ticks(input string tag);
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            check_eq(tag, 32'(state), 32'd4);
        end
    endtask

    initial begin
        // Reset values
        #12;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_scores", {24'(lscore), 8'(rscore)}, 32'd0);
        check_eq("rst_flags", {27'd0, lws, rws, big, go, lwin}, 32'd0);
        check_eq("rst_point", 32'(point), 32'd0);
        #5 rst_n = 1'b1;
        #1 check_eq("idle_hold", 32'(state), 32'd0);
        cyc();
        check_eq("first_serve", 32'(state), 32'd1);
        check_eq("lws", 32'(lws), 32'd1);

        // Non-serving click and misses ignored in LEFT_SERVE
        rclick = 1'b1; lmiss = 1'b1; rmiss = 1'b1;
        cyc();
        rclick = 1'b0; lmiss = 1'b0; rmiss = 1'b0;
        check_eq("serve_ignore", 32'(state), 32'd1);
        check_eq("serve_ignore_sc", 32'(rscore), 32'd0);

        lclick = 1'b1; cyc(); lclick = 1'b0;
        check_eq("in_play", 32'(state), 32'd3);
        check_eq("big", 32'(big), 32'd1);

        lmiss = 1'b1; cyc(); lmiss = 1'b0;
        check_eq("pp1_state", 32'(state), 32'd4);
        check_eq("pp1_rscore", 32'(rscore), 32'd1);
        check_eq("pp1_point", 32'(point), 32'd1);
        cyc();
        check_eq("pp1_point_off", 32'(point), 32'd0);
        pause_ticks("pp1_hold");
        cyc();
        check_eq("pp1_exit_rs", 32'(state), 32'd2);
        check_eq("rws", 32'(rws), 32'd1);

        rclick = 1'b1; cyc(); rclick = 1'b0;
        check_eq("in_play2", 32'(state), 32'd3);
        lmiss = 1'b1; cyc(); lmiss = 1'b0;
        check_eq("pp2_rscore", 32'(rscore), 32'd2);
        check_eq("pp2_point", 32'(point), 32'd1);
        pause_ticks("pp2_hold");
        cyc();
        check_eq("game_over", 32'(state), 32'd5);
        check_eq("go_flag", 32'(go), 32'd1);
        check_eq("left_winner", 32'(lwin), 32'd0);
        cyc();
        check_eq("go_hold_state", 32'(state), 32'd5);
        check_eq("go_hold_scores", {24'(lscore), 8'(rscore)}, 32'd2);

        lclick = 1'b1; cyc(); lclick = 1'b0;
        check_eq("restart_idle", 32'(state), 32'd0);
        check_eq("restart_scores", {24'(lscore), 8'(rscore)}, 32'd0);
        cyc();
        check_eq("restart_serve", 32'(state), 32'd1);

        // Simultaneous misses: left miss wins
        lclick = 1'b1; cyc(); lclick = 1'b0;
        lmiss = 1'b1; rmiss = 1'b1; cyc(); lmiss = 1'b0; rmiss = 1'b0;
        check_eq("both_state", 32'(state), 32'd4);
        check_eq("both_scores", {24'(lscore), 8'(rscore)}, 32'd1);
        check_eq("both_point", 32'(point), 32'd1);
        pause_ticks("both_hold");
        cyc();
        check_eq("both_next_rs", 32'(state), 32'd2);

        // Right miss, then reset mid-pause
        rclick = 1'b1; cyc(); rclick = 1'b0;
        rmiss = 1'b1; cyc(); rmiss = 1'b0;
        check_eq("rmiss_scores", {24'(lscore), 8'(rscore)}, 32'h101);
        check_eq("rmiss_point", 32'(point), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_state", 32'(state), 32'd0);
        check_eq("arst_scores", {24'(lscore), 8'(rscore)}, 32'd0);
        check_eq("arst_point", 32'(point), 32'd0);
        #2 rst_n = 1'b1;
        cyc();
        check_eq("arst_exit", 32'(state), 32'd1);

        // Auto-serve on the 4th tick, or none at all without the feature
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            check_eq("auto_wait", 32'(state), 32'd1);
        end
        pulse_tick();
`ifdef MATCH_CTRL_AUTO_SERVE_EN
        check_eq("auto_serve", 32'(state), 32'd3);
`else
        check_eq("no_auto_serve", 32'(state), 32'd1);
        for (int i = 0; i < 6; i++) begin
            pulse_tick();
        end
        check_eq("no_auto_serve_long", 32'(state), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
